// File: rtl/mvu_pkg.sv
// Shared AXI encodings and FSM state type for the MVU AXI master port.
package mvu_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_EXOKAY = 2'b01,
        AXI_RESP_SLVERR = 2'b10,
        AXI_RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_B,
        ST_READ,
        ST_WAIT_R
    } mvu_axim_state_e;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

endpackage

// File: rtl/mvu_axi_master_port.sv
// Bridges a req/gnt/rvalid memory port onto single-beat AXI4 transactions,
// one outstanding at a time.
module mvu_axi_master_port
    import mvu_pkg::*;
#(
    parameter int unsigned            AxiIdWidth   = 6,
    parameter int unsigned            AxiAddrWidth = 32,
    parameter int unsigned            AxiDataWidth = 32,
    parameter logic [AxiIdWidth-1:0]  AxiId        = '0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mem_req_i,
    output logic                      mem_gnt_o,
    input  logic                      mem_we_i,
    input  logic [AxiAddrWidth-1:0]   mem_addr_i,
    input  logic [AxiDataWidth/8-1:0] mem_be_i,
    input  logic [AxiDataWidth-1:0]   mem_wdata_i,
    output logic                      mem_rvalid_o,
    output logic [AxiDataWidth-1:0]   mem_rdata_o,
    output logic                      mem_err_o,
    output logic                      busy_o,
    output logic [AxiIdWidth-1:0]     aw_id_o,
    output logic [AxiAddrWidth-1:0]   aw_addr_o,
    output logic [7:0]                aw_len_o,
    output logic [2:0]                aw_size_o,
    output logic [1:0]                aw_burst_o,
    output logic                      aw_valid_o,
    input  logic                      aw_ready_i,
    output logic [AxiDataWidth-1:0]   w_data_o,
    output logic [AxiDataWidth/8-1:0] w_strb_o,
    output logic                      w_last_o,
    output logic                      w_valid_o,
    input  logic                      w_ready_i,
    input  logic [AxiIdWidth-1:0]     b_id_i,
    input  logic [1:0]                b_resp_i,
    input  logic                      b_valid_i,
    output logic                      b_ready_o,
    output logic [AxiIdWidth-1:0]     ar_id_o,
    output logic [AxiAddrWidth-1:0]   ar_addr_o,
    output logic [7:0]                ar_len_o,
    output logic [2:0]                ar_size_o,
    output logic [1:0]                ar_burst_o,
    output logic                      ar_valid_o,
    input  logic                      ar_ready_i,
    input  logic [AxiIdWidth-1:0]     r_id_i,
    input  logic [AxiDataWidth-1:0]   r_data_i,
    input  logic [1:0]                r_resp_i,
    input  logic                      r_last_i,
    input  logic                      r_valid_i,
    output logic                      r_ready_o
);

    if (AxiDataWidth != 32) begin : g_width_check
        $error("mvu_axi_master_port supports only AxiDataWidth = 32");
    end

    mvu_axim_state_e           state_q, state_d;
    logic [AxiAddrWidth-1:0]   addr_q, addr_d;
    logic [AxiDataWidth/8-1:0] be_q, be_d;
    logic [AxiDataWidth-1:0]   wdata_q, wdata_d;
    logic [AxiDataWidth-1:0]   rdata_q, rdata_d;
    logic                      aw_done_q, aw_done_d;
    logic                      w_done_q, w_done_d;
    logic                      rvalid_q, rvalid_d;
    logic                      err_q, err_d;
    logic                      accept;

    // Single outstanding transaction: IDs, r_last and the low resp bit carry no information.
    logic unused_inputs;
    assign unused_inputs = ^{b_id_i, r_id_i, r_last_i, b_resp_i[0], r_resp_i[0]};

    assign accept    = mem_req_i & (state_q == ST_IDLE) & ~rst_i;
    assign mem_gnt_o = accept;
    assign busy_o    = (state_q != ST_IDLE);

    assign aw_id_o    = AxiId;
    assign aw_addr_o  = addr_q;
    assign aw_len_o   = '0;
    assign aw_size_o  = AXI_SIZE_4B;
    assign aw_burst_o = AXI_BURST_INCR;
    assign w_data_o   = wdata_q;
    assign w_strb_o   = be_q;
    assign w_last_o   = 1'b1;
    assign ar_id_o    = AxiId;
    assign ar_addr_o  = addr_q;
    assign ar_len_o   = '0;
    assign ar_size_o  = AXI_SIZE_4B;
    assign ar_burst_o = AXI_BURST_INCR;

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_err_o    = err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        rvalid_d   = 1'b0;
        err_d      = err_q;
        aw_valid_o = 1'b0;
        w_valid_o  = 1'b0;
        b_ready_o  = 1'b0;
        ar_valid_o = 1'b0;
        r_ready_o  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d    = mem_addr_i;
                    be_d      = mem_be_i;
                    wdata_d   = mem_wdata_i;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = mem_we_i ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                // AW and W complete independently; leave once both have handshaken.
                aw_valid_o = ~aw_done_q;
                w_valid_o  = ~w_done_q;
                aw_done_d  = aw_done_q | (aw_valid_o & aw_ready_i);
                w_done_d   = w_done_q | (w_valid_o & w_ready_i);
                if (aw_done_d & w_done_d) begin
                    state_d = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                b_ready_o = 1'b1;
                if (b_valid_i) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = '0;
                    err_d    = b_resp_i[1];
                end
            end
            ST_READ: begin
                ar_valid_o = 1'b1;
                if (ar_ready_i) begin
                    state_d = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                r_ready_o = 1'b1;
                if (r_valid_i) begin
                    state_d  = ST_IDLE;
                    rvalid_d = 1'b1;
                    rdata_d  = r_data_i;
                    err_d    = r_resp_i[1];
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_mvu_axi_master_port.sv
// Self-checking bench: cycle-exact expectations derived from channel wait counts,
// plus a byte-strobed memory model for read data.
module tb_mvu_axi_master_port;
    import mvu_pkg::*;

    localparam int unsigned    IW    = 6;
    localparam logic [IW-1:0]  TB_ID = 6'h2B;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          mem_req_i, mem_gnt_o, mem_we_i;
    logic [31:0]   mem_addr_i, mem_wdata_i, mem_rdata_o;
    logic [3:0]    mem_be_i;
    logic          mem_rvalid_o, mem_err_o, busy_o;
    logic [IW-1:0] aw_id_o, ar_id_o, b_id_i, r_id_i;
    logic [31:0]   aw_addr_o, ar_addr_o, w_data_o, r_data_i;
    logic [7:0]    aw_len_o, ar_len_o;
    logic [2:0]    aw_size_o, ar_size_o;
    logic [1:0]    aw_burst_o, ar_burst_o, b_resp_i, r_resp_i;
    logic [3:0]    w_strb_o;
    logic          aw_valid_o, aw_ready_i, w_last_o, w_valid_o, w_ready_i;
    logic          b_valid_i, b_ready_o, ar_valid_o, ar_ready_i;
    logic          r_last_i, r_valid_i, r_ready_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_mem   [int unsigned];
    logic [31:0] slave_mem [int unsigned];

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          aw_w, w_w, b_w, ar_w, r_w;
        logic [1:0]  resp;
    } txn_t;

    mvu_axi_master_port #(
        .AxiIdWidth  (IW),
        .AxiAddrWidth(32),
        .AxiDataWidth(32),
        .AxiId       (TB_ID)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_req_i(mem_req_i), .mem_gnt_o(mem_gnt_o), .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i), .mem_be_i(mem_be_i), .mem_wdata_i(mem_wdata_i),
        .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .busy_o(busy_o),
        .aw_id_o(aw_id_o), .aw_addr_o(aw_addr_o), .aw_len_o(aw_len_o), .aw_size_o(aw_size_o),
        .aw_burst_o(aw_burst_o), .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i),
        .w_data_o(w_data_o), .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .b_id_i(b_id_i), .b_resp_i(b_resp_i), .b_valid_i(b_valid_i), .b_ready_o(b_ready_o),
        .ar_id_o(ar_id_o), .ar_addr_o(ar_addr_o), .ar_len_o(ar_len_o), .ar_size_o(ar_size_o),
        .ar_burst_o(ar_burst_o), .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i),
        .r_id_i(r_id_i), .r_data_i(r_data_i), .r_resp_i(r_resp_i), .r_last_i(r_last_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] w;
        w = old;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        return w;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        int unsigned k;
        k = 32'(a[31:2]);
        return exp_mem.exists(k) ? exp_mem[k] : init_word(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        int unsigned k;
        k = 32'(a[31:2]);
        return slave_mem.exists(k) ? slave_mem[k] : init_word(a);
    endfunction

    function automatic txn_t mk(input bit we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input int aw_w, input int w_w,
                                input int b_w, input int ar_w, input int r_w,
                                input logic [1:0] resp);
        txn_t t;
        t.we = we; t.addr = addr; t.be = be; t.wdata = wdata;
        t.aw_w = aw_w; t.w_w = w_w; t.b_w = b_w; t.ar_w = ar_w; t.r_w = r_w; t.resp = resp;
        return t;
    endfunction

    task automatic drive_req(input txn_t t);
        mem_req_i = 1'b1; mem_we_i = t.we; mem_addr_i = t.addr;
        mem_be_i = t.be; mem_wdata_i = t.wdata;
    endtask

    task automatic scramble_req();
        mem_req_i = 1'b0; mem_we_i = 1'($urandom); mem_addr_i = $urandom;
        mem_be_i = 4'($urandom); mem_wdata_i = $urandom;
    endtask

    task automatic clear_slave();
        aw_ready_i = 1'b0; w_ready_i = 1'b0; b_valid_i = 1'b0; ar_ready_i = 1'b0;
        r_valid_i = 1'b0; b_resp_i = 2'($urandom); r_resp_i = 2'($urandom);
        b_id_i = IW'($urandom); r_id_i = IW'($urandom); r_last_i = 1'($urandom);
        r_data_i = $urandom;
    endtask

    // Cycle 0 is the grant cycle; every later cycle has a fully predicted control vector.
    task automatic run_txn(input string tag, input txn_t t, input bit chained, input bit hold_req,
                           input bit chain_next, input txn_t nxt);
        int aw_win, w_win, d, b_at, ar_at, r_at, rv_at, last;
        bit aw_seen, w_seen, b_seen, r_seen, applied;
        logic [31:0] aw_cap, ar_cap, w_cap, want_rd;
        logic [3:0]  w_cap_be;
        logic        want_err;
        logic [7:0]  exp_ctl, got_ctl;

        aw_win = 1 + t.aw_w; w_win = 1 + t.w_w;
        d      = (aw_win > w_win) ? aw_win : w_win;
        b_at   = d + 1 + t.b_w;
        ar_at  = 1 + t.ar_w;
        r_at   = ar_at + 1 + t.r_w;
        rv_at  = t.we ? b_at + 1 : r_at + 1;
        last   = chain_next ? rv_at : rv_at + 1;
        aw_seen = 0; w_seen = 0; b_seen = 0; r_seen = 0; applied = 0;
        aw_cap = '0; ar_cap = '0; w_cap = '0; w_cap_be = '0;
        want_err = t.resp[1];
        if (t.we) begin
            want_rd = '0;
            exp_mem[32'(t.addr[31:2])] = merge(exp_rd(t.addr), t.be, t.wdata);
        end else begin
            want_rd = exp_rd(t.addr);
        end

        if (!chained) begin
            @(negedge clk_i);
            clear_slave();
            drive_req(t);
            #1;
            checks++;
            if ({mem_gnt_o, busy_o} !== 2'b10)
                begin failures++; $display("FAIL %s grant: got gnt,busy=%b want 10", tag, {mem_gnt_o, busy_o}); end
        end

        for (int c = 1; c <= last; c++) begin
            @(negedge clk_i);
            clear_slave();
            if (c == rv_at && chain_next) drive_req(nxt);
            else if (hold_req && c < rv_at) drive_req(t);
            else scramble_req();
            aw_ready_i = t.we && c >= aw_win && c < rv_at;
            w_ready_i  = t.we && c >= w_win && c < rv_at;
            b_valid_i  = t.we && c >= b_at && !b_seen && c < rv_at;
            b_resp_i   = t.resp;
            ar_ready_i = !t.we && c >= ar_at && c < rv_at;
            r_valid_i  = !t.we && c >= r_at && !r_seen && c < rv_at;
            r_resp_i   = t.resp;
            r_data_i   = slave_rd(ar_cap);
            #1;
            exp_ctl = {mem_req_i && (c == rv_at), c < rv_at,
                       t.we && (c <= aw_win), t.we && (c <= w_win),
                       t.we && (c > d) && (c <= b_at),
                       !t.we && (c <= ar_at), !t.we && (c > ar_at) && (c <= r_at),
                       c == rv_at};
            got_ctl = {mem_gnt_o, busy_o, aw_valid_o, w_valid_o, b_ready_o,
                       ar_valid_o, r_ready_o, mem_rvalid_o};
            checks++;
            if (got_ctl !== exp_ctl)
                begin failures++; $display("FAIL %s ctrl c=%0d got=%b want=%b (gnt busy aw w b ar r rvalid)", tag, c, got_ctl, exp_ctl); end
            if (aw_valid_o) begin
                checks++;
                if ({aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o} !== {TB_ID, t.addr, 8'h00, 3'b010, 2'b01})
                    begin failures++; $display("FAIL %s aw_payload c=%0d got=%h/%h/%h/%h/%h want %h/%h/00/2/1", tag, c, aw_id_o, aw_addr_o, aw_len_o, aw_size_o, aw_burst_o, TB_ID, t.addr); end
            end
            if (w_valid_o) begin
                checks++;
                if ({w_data_o, w_strb_o, w_last_o} !== {t.wdata, t.be, 1'b1})
                    begin failures++; $display("FAIL %s w_payload c=%0d got=%h/%h/%b want %h/%h/1", tag, c, w_data_o, w_strb_o, w_last_o, t.wdata, t.be); end
            end
            if (ar_valid_o) begin
                checks++;
                if ({ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o} !== {TB_ID, t.addr, 8'h00, 3'b010, 2'b01})
                    begin failures++; $display("FAIL %s ar_payload c=%0d got=%h/%h/%h/%h/%h want %h/%h/00/2/1", tag, c, ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o, TB_ID, t.addr); end
            end
            if (c == rv_at) begin
                checks++;
                if ({mem_rdata_o, mem_err_o} !== {want_rd, want_err})
                    begin failures++; $display("FAIL %s completion got rdata=%h err=%b want rdata=%h err=%b", tag, mem_rdata_o, mem_err_o, want_rd, want_err); end
            end
            if (aw_valid_o && aw_ready_i) begin aw_seen = 1; aw_cap = aw_addr_o; end
            if (w_valid_o && w_ready_i) begin w_seen = 1; w_cap = w_data_o; w_cap_be = w_strb_o; end
            if (ar_valid_o && ar_ready_i) ar_cap = ar_addr_o;
            if (b_valid_i && b_ready_o) b_seen = 1;
            if (r_valid_i && r_ready_o) r_seen = 1;
            if (aw_seen && w_seen && !applied) begin
                slave_mem[32'(aw_cap[31:2])] = merge(slave_rd(aw_cap), w_cap_be, w_cap);
                applied = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        clear_slave();
        mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'hFFFF_FFFC;
        mem_be_i = 4'hF; mem_wdata_i = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if ({mem_gnt_o, busy_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, mem_rvalid_o, mem_err_o} !== 9'b0)
            begin failures++; $display("FAIL reset_ctrl got=%b want=000000000", {mem_gnt_o, busy_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, mem_rvalid_o, mem_err_o}); end
        checks++;
        if ({aw_addr_o, ar_addr_o, w_data_o, w_strb_o, mem_rdata_o} !== 132'b0)
            begin failures++; $display("FAIL reset_payload got aw=%h ar=%h w=%h strb=%h rdata=%h want all 0", aw_addr_o, ar_addr_o, w_data_o, w_strb_o, mem_rdata_o); end
        @(negedge clk_i);
        rst_i = 1'b0;
        scramble_req();
    endtask

    task automatic test_write_basic();
        txn_t t;
        t = mk(1, 32'h0020_2004, 4'hF, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        run_txn("write_basic", t, 0, 0, 0, t);
    endtask

    task automatic test_read_wait();
        txn_t t;
        exp_mem[32'(32'h7000_0010 >> 2)]   = 32'h1234_5678;
        slave_mem[32'(32'h7000_0010 >> 2)] = 32'h1234_5678;
        t = mk(0, 32'h7000_0010, 4'h0, 32'h0, 0, 0, 0, 3, 5, AXI_RESP_OKAY);
        run_txn("read_wait", t, 0, 1, 0, t);
    endtask

    task automatic test_write_wstall();
        txn_t t;
        t = mk(1, 32'h0010_0008, 4'h5, 32'hA1B2_C3D4, 0, 4, 1, 0, 0, AXI_RESP_OKAY);
        run_txn("write_wstall", t, 0, 0, 0, t);
        t = mk(1, 32'h0010_000C, 4'hA, 32'h0F0E_0D0C, 3, 0, 0, 0, 0, AXI_RESP_SLVERR);
        run_txn("write_awstall", t, 0, 0, 0, t);
    endtask

    task automatic test_read_err();
        txn_t t;
        t = mk(0, 32'h0010_0008, 4'h0, 32'h0, 0, 0, 0, 0, 1, AXI_RESP_DECERR);
        run_txn("read_decerr", t, 0, 0, 0, t);
        t = mk(0, 32'h0010_0008, 4'h0, 32'h0, 0, 0, 0, 1, 0, AXI_RESP_OKAY);
        run_txn("read_okay_after_err", t, 0, 0, 0, t);
    endtask

    task automatic test_back_to_back();
        txn_t t0, t1, t2;
        t0 = mk(0, 32'h7000_0010, 4'h0, 32'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        t1 = mk(0, 32'h0020_2004, 4'h0, 32'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        t2 = mk(0, 32'h0010_000C, 4'h0, 32'h0, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        run_txn("b2b_0", t0, 0, 0, 1, t1);
        run_txn("b2b_1", t1, 1, 0, 1, t2);
        run_txn("b2b_2", t2, 1, 0, 0, t2);
    endtask

    task automatic test_reset_midtxn();
        txn_t t;
        t = mk(1, 32'h0030_0000, 4'hF, 32'h5555_AAAA, 0, 0, 0, 0, 0, AXI_RESP_OKAY);
        @(negedge clk_i); clear_slave(); drive_req(t); #1;
        checks++;
        if (mem_gnt_o !== 1'b1) begin failures++; $display("FAIL midrst_grant got=%b want=1", mem_gnt_o); end
        @(negedge clk_i); clear_slave(); scramble_req(); aw_ready_i = 1'b1; w_ready_i = 1'b1; #1;
        checks++;
        if ({aw_valid_o, w_valid_o} !== 2'b11) begin failures++; $display("FAIL midrst_write got aw,w=%b want 11", {aw_valid_o, w_valid_o}); end
        @(negedge clk_i); clear_slave(); #1;
        checks++;
        if ({b_ready_o, busy_o} !== 2'b11) begin failures++; $display("FAIL midrst_waitb got bready,busy=%b want 11", {b_ready_o, busy_o}); end
        @(negedge clk_i); clear_slave(); rst_i = 1'b1;
        @(negedge clk_i); clear_slave(); rst_i = 1'b0; #1;
        checks++;
        if ({busy_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, mem_rvalid_o} !== 7'b0)
            begin failures++; $display("FAIL midrst_after got=%b want=0000000 (busy aw w b ar r rvalid)", {busy_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o, mem_rvalid_o}); end
        checks++;
        if ({aw_addr_o, w_data_o, w_strb_o} !== 68'b0)
            begin failures++; $display("FAIL midrst_payload got aw=%h w=%h strb=%h want 0", aw_addr_o, w_data_o, w_strb_o); end
        t = mk(0, 32'h0020_2004, 4'h0, 32'h0, 1, 0, 0, 1, 2, AXI_RESP_OKAY);
        run_txn("after_midrst", t, 0, 0, 0, t);
    endtask

    task automatic test_random();
        txn_t q[$];
        bit   chain[$];
        txn_t t;
        for (int i = 0; i < 30; i++) begin
            t = mk(1'($urandom), 32'h1000_0000 + 32'(($urandom % 4) * 4) + 32'($urandom % 4),
                   4'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), 2'($urandom));
            q.push_back(t);
            chain.push_back(1'($urandom));
        end
        for (int i = 0; i < 30; i++) begin
            run_txn($sformatf("rand%0d", i), q[i], (i > 0) && chain[i-1], 1'($urandom),
                    (i < 29) && chain[i], q[(i < 29) ? i + 1 : i]);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_wait();
        test_write_wstall();
        test_read_err();
        test_back_to_back();
        test_reset_midtxn();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mvu_axi_master_port.md
Name: mvu_axi_master_port

Overview:
- Initiator-side bridge: converts a simple req/gnt/rvalid memory port into single-beat AXI4 master transactions.
- Lets the pito core or an MVU controller read and write any target on the SoC crossbar: IMEM, DMEM, MVU0..7MEM.
- One transaction outstanding at a time. Fixed ID, fixed 32-bit beats, no bursts, no ATOPs.

Parameters:
- AxiIdWidth, 6, width of AXI ID fields.
- AxiAddrWidth, 32, AXI/memory address width.
- AxiDataWidth, 32, data width. Only 32 is supported; elaboration fails otherwise.
- AxiId, 0, constant ID driven on aw_id_o and ar_id_o.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- mem_req_i  in  1  request valid.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_addr_i  in  AxiAddrWidth  byte address.
- mem_be_i  in  AxiDataWidth/8  byte enables (writes only).
- mem_wdata_i  in  AxiDataWidth  write data.
- mem_rvalid_o  out  1  one-cycle completion pulse, for reads and writes.
- mem_rdata_o  out  AxiDataWidth  read data; 0 on write completion.
- mem_err_o  out  1  valid with mem_rvalid_o; 1 if resp is SLVERR or DECERR.
- busy_o  out  1  state != IDLE.
- aw_id_o, aw_addr_o, aw_len_o[7:0], aw_size_o[2:0], aw_burst_o[1:0]  out  AW payload.
- aw_valid_o  out  1.  aw_ready_i  in  1.
- w_data_o, w_strb_o, w_last_o  out  W payload.
- w_valid_o  out  1.  w_ready_i  in  1.
- b_id_i  in  AxiIdWidth.  b_resp_i  in  2.  b_valid_i  in  1.  b_ready_o  out  1.
- ar_id_o, ar_addr_o, ar_len_o, ar_size_o, ar_burst_o  out  AR payload.
- ar_valid_o  out  1.  ar_ready_i  in  1.
- r_id_i  in  AxiIdWidth.  r_data_i  in  AxiDataWidth.  r_resp_i  in  2.  r_last_i  in  1.  r_valid_i  in  1.  r_ready_o  out  1.

Behaviour:
- Reset (sync, rst_i = 1): state IDLE. All valid/ready outputs 0. mem_gnt_o, mem_rvalid_o, mem_err_o, busy_o are 0. Payload registers cleared to 0.
- Constant AXI fields: len = 0, size = 3'b010, burst = INCR (2'b01), w_last_o = 1, id = AxiId.
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R.
- Acceptance: mem_gnt_o = mem_req_i & (state == IDLE), combinational. On acceptance, addr/we/be/wdata are latched into registers, and AXI payloads are driven only from these registers.
- IDLE -> WRITE (we = 1) or READ (we = 0) on acceptance.
- WRITE:
  - aw_valid_o and w_valid_o both rise in the first WRITE cycle.
  - Each is tracked by its own done flag. A valid drops the cycle after its own handshake; the two channels are independent, so either may complete first or both in the same cycle.
  - Valids never drop before their handshake.
  - When both flags are set (including same-cycle completion), go to WAIT_B.
- WAIT_B: b_ready_o = 1. On b_valid_i, go to IDLE. Next cycle: mem_rvalid_o = 1, mem_rdata_o = 0, mem_err_o = b_resp_i[1].
- READ: ar_valid_o = 1 until ar_ready_i, then go to WAIT_R.
- WAIT_R: r_ready_o = 1. On r_valid_i, go to IDLE. Next cycle: mem_rvalid_o = 1, mem_rdata_o = r_data_i (registered), mem_err_o = r_resp_i[1].
- Outside WAIT_B/WAIT_R, b_ready_o and r_ready_o are 0.
- b_id_i and r_id_i are not checked (single outstanding transaction). r_last_i is ignored.
- mem_rdata_o and mem_err_o hold their value until the next completion.
- Minimum latency with zero-wait slaves, gnt at cycle 0:
  - write: AW/W handshake in cycle 1, B in cycle 2, rvalid in cycle 3.
  - read: AR handshake in cycle 1, R in cycle 2, rvalid in cycle 3.
- A new grant is possible in the same cycle as mem_rvalid_o, giving back-to-back throughput of one transaction per 3 cycles.
- Reset mid-transaction: immediate return to IDLE; all valids drop the next edge regardless of handshake state. The system guarantees the slave side is reset concurrently.
- Addresses are passed unaligned-as-is. The slave uses strobes for byte lanes.

Decomposition:
- mvu_pkg gets:
  - axi_resp encodings: OKAY, EXOKAY, SLVERR, DECERR.
  - the mvu_axim_state_e enum.
  - localparams AXI_SIZE_4B and AXI_BURST_INCR.
- No sub-module: a single FSM plus payload registers. An AXI_BUS.Master wrapper can be added separately using the axi assign macros.

Test Plan:
- Write 0xDEADBEEF, be = 4'hF, addr 0x0020_2004, aw/w/b ready every cycle -> aw_addr 0x00202004, w_strb F, w_last 1, mem_rvalid at cycle 3, err 0.
- Read 0x7000_0010, slave returns 0x12345678 with OKAY after 5 wait cycles -> ar_valid held until ar_ready, rdata 0x12345678, rvalid exactly one cycle, gnt low while busy.
- Write with w_ready 0 for 4 cycles while aw_ready = 1 -> aw_valid drops after 1 cycle, w_valid held 5 cycles, B is waited for only after W completes.
- Read with r_resp = 2'b11 (DECERR) -> mem_err_o = 1 with rvalid. A following OKAY read clears it.
- Back-to-back: mem_req held high for 3 reads -> gnt pulses at cycles 0, 3, 6; one rvalid per read, in order.
- rst_i asserted while in WAIT_B -> next cycle busy_o 0, all valid/ready outputs 0, mem_rvalid_o 0. A new request afterwards completes normally.
